// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op encodings, FSM states and constants for shift_sequencer
package shift_pkg;
  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;
  localparam logic [DATA_W-1:0] MSB_MASK = 16'h8000;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_ROR  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PASS_A,
    S_PASS_B,
    S_PASS_C,
    S_RESP
  } state_e;
endpackage

// File: rtl/shifter.sv
// rtl/shifter.sv - 16-bit barrel shifter: Mode 0 logical left, Mode 1 arithmetic right
module shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] Shift_In,
  input  logic [AMT_W-1:0]  Shift_Val,
  input  logic              Mode,
  output logic [DATA_W-1:0] Shift_Out
);
  logic [DATA_W-1:0] sra_out;

  // Arithmetic shift kept in its own self-determined expression so signedness survives.
  always_comb begin
    sra_out   = $unsigned($signed(Shift_In) >>> Shift_Val);
    Shift_Out = Mode ? sra_out : (Shift_In << Shift_Val);
  end
endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - valid/ready sequencer around one shifter; ROR via SHIFT_SEQ_ROR_EN
module shift_sequencer
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  input  logic [AMT_W-1:0]  req_amt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);
  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_valid_q, rsp_valid_d;
`ifdef SHIFT_SEQ_ROR_EN
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] y_q, y_d;
`endif

  logic [DATA_W-1:0] sh_in, sh_out;
  logic [AMT_W-1:0]  sh_val;
  logic              sh_mode;

  shifter u_shifter (
    .Shift_In  (sh_in),
    .Shift_Val (sh_val),
    .Mode      (sh_mode),
    .Shift_Out (sh_out)
  );

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    sh_in   = data_q;
    sh_val  = amt_q;
    sh_mode = 1'b0;
    case (state_q)
      S_PASS_A: begin
        if (op_q == OP_SRA) sh_mode = 1'b1;
`ifdef SHIFT_SEQ_ROR_EN
        if (op_q == OP_ROR) sh_val = 4'd0 - amt_q;
`endif
      end
`ifdef SHIFT_SEQ_ROR_EN
      S_PASS_B: sh_mode = 1'b1;
      S_PASS_C: begin
        sh_in   = MSB_MASK;
        sh_val  = amt_q - 4'd1;
        sh_mode = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    amt_d      = amt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
`ifdef SHIFT_SEQ_ROR_EN
    a_d = a_q;
    y_d = y_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = op_e'(req_op);
          data_d  = req_data;
          amt_d   = req_amt;
          state_d = S_PASS_A;
        end
      end
      S_PASS_A: begin
        state_d   = S_RESP;
        rsp_err_d = 1'b0;
        case (op_q)
          OP_SLL, OP_SRA: rsp_data_d = sh_out;
`ifdef SHIFT_SEQ_ROR_EN
          OP_ROR: begin
            if (amt_q == '0) begin
              rsp_data_d = sh_out;
            end else begin
              a_d     = sh_out;
              state_d = S_PASS_B;
            end
          end
`endif
          default: begin
            rsp_data_d = data_q;
            rsp_err_d  = 1'b1;
          end
        endcase
      end
`ifdef SHIFT_SEQ_ROR_EN
      S_PASS_B: begin
        y_d     = sh_out;
        state_d = S_PASS_C;
      end
      // sh_out is the top-n mask; it strips the sign fill that SRA dragged in.
      S_PASS_C: begin
        rsp_data_d = (y_q & ~sh_out) | a_q;
        state_d    = S_RESP;
      end
`endif
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_SLL;
      data_q      <= '0;
      amt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef SHIFT_SEQ_ROR_EN
      a_q <= '0;
      y_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      amt_q       <= amt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef SHIFT_SEQ_ROR_EN
      a_q <= a_d;
      y_q <= y_d;
`endif
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer, both SHIFT_SEQ_ROR_EN builds
module tb_shift_sequencer;
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_data;
  logic [3:0]  req_amt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] d;
    logic        e;
    int          lat;
  } exp_t;
  exp_t sb[$];

`ifdef SHIFT_SEQ_ROR_EN
  localparam bit ROR_EN = 1'b1;
`else
  localparam bit ROR_EN = 1'b0;
`endif

  shift_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [15:0] d, input logic [3:0] a);
    exp_t        r;
    logic [31:0] w;
    r.e   = 1'b0;
    r.lat = 2;
    case (op)
      2'b00: r.d = 16'(d << a);
      2'b01: begin
        w   = {{16{d[15]}}, d} >> a;
        r.d = w[15:0];
      end
      2'b10: begin
        if (ROR_EN) begin
          w   = ({16'h0, d} >> a) | ({16'h0, d} << (16 - int'(a)));
          r.d = w[15:0];
          r.lat = (a == 4'd0) ? 2 : 4;
        end else begin
          r.d = d;
          r.e = 1'b1;
        end
      end
      default: begin
        r.d = d;
        r.e = 1'b1;
      end
    endcase
    return r;
  endfunction

  task automatic issue(input string tag, input logic [1:0] op, input logic [15:0] d,
                       input logic [3:0] a, input exp_t e);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    req_amt   = a;
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_data  = 16'($urandom);
    req_amt   = 4'($urandom);
  endtask

  task automatic wait_rsp(input string tag);
    int   edges;
    exp_t e;
    edges = 1;
    while (rsp_valid !== 1'b1 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    e = sb.pop_front();
    chk({tag, " latency"}, 32'(edges), 32'(e.lat));
    chk({tag, " rsp_data"}, 32'(rsp_data), 32'(e.d));
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'(e.e));
  endtask

  task automatic handshake(input string tag);
    @(posedge clk);
    #1;
    chk({tag, " rsp_valid after hs"}, 32'(rsp_valid), 32'd0);
    chk({tag, " req_ready after hs"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [15:0] d,
                     input logic [3:0] a, input exp_t e);
    issue(tag, op, d, a, e);
    wait_rsp(tag);
    handshake(tag);
  endtask

  function automatic exp_t mk(input logic [15:0] d, input logic e, input int lat);
    exp_t r;
    r.d = d;
    r.e = e;
    r.lat = lat;
    return r;
  endfunction

  initial begin
    logic [1:0]  rop;
    logic [15:0] rd;
    logic [3:0]  ra;

    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_data = 16'h0;
    req_amt = 4'h0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_data", 32'(rsp_data), 32'h0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("release req_ready", 32'(req_ready), 32'd1);

    run("sll_f1_4", 2'b00, 16'h00F1, 4'd4, mk(16'h0F10, 1'b0, 2));
    run("sra_8010_4", 2'b01, 16'h8010, 4'd4, mk(16'hF801, 1'b0, 2));
    run("sra_7fff_15", 2'b01, 16'h7FFF, 4'd15, mk(16'h0000, 1'b0, 2));
    if (ROR_EN) begin
      run("ror_1234_4", 2'b10, 16'h1234, 4'd4, mk(16'h4123, 1'b0, 4));
      run("ror_8001_1", 2'b10, 16'h8001, 4'd1, mk(16'hC000, 1'b0, 4));
    end else begin
      run("ror_off_1234_4", 2'b10, 16'h1234, 4'd4, mk(16'h1234, 1'b1, 2));
      run("ror_off_8001_1", 2'b10, 16'h8001, 4'd1, mk(16'h8001, 1'b1, 2));
    end
    run("ror_abcd_0", 2'b10, 16'hABCD, 4'd0, mk(16'hABCD, ROR_EN ? 1'b0 : 1'b1, 2));
    run("rsvd_5a5a", 2'b11, 16'h5A5A, 4'd7, mk(16'h5A5A, 1'b1, 2));

    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom);
      rd  = 16'($urandom);
      ra  = 4'($urandom);
      run($sformatf("rand%0d_op%0d", i, rop), rop, rd, ra, model(rop, rd, ra));
    end

    // Backpressure, with a second request waiting behind the stalled response.
    rsp_ready = 1'b0;
    issue("bp_first", 2'b00, 16'h00F1, 4'd4, mk(16'h0F10, 1'b0, 2));
    wait_rsp("bp_first");
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_data  = 16'h8010;
    req_amt   = 4'd4;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp hold%0d rsp_data", i), 32'(rsp_data), 32'h0F10);
      chk($sformatf("bp hold%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp hold%0d req_ready", i), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp hs rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp hs req_ready", 32'(req_ready), 32'd1);
    sb.push_back(mk(16'hF801, 1'b0, 2));
    @(posedge clk);
    #1;
    chk("bp second accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    wait_rsp("bp_second");
    handshake("bp_second");

    // Reset while a ROR is two edges into its sequence.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_data  = 16'h1234;
    req_amt   = 4'd4;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd0);
    chk("midrst rsp_data", 32'(rsp_data), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("postrst quiet%0d", i), 32'(rsp_valid), 32'd0);
    end
    run("postrst_sll", 2'b00, 16'h0001, 4'd1, mk(16'h0002, 1'b0, 2));
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
